// File: rtl/recover_pix_if.sv
// Pixel / transmission stream bundle for recover_pix.
// The master side supplies raw pixels, atmospheric light and 1/t.
// The slave side returns the recovered pixel strobe.
interface recover_pix_if #(
  parameter int CW = 8
);
  logic [3*CW-1:0] pix_in;
  logic            pix_valid;
  logic [3*CW-1:0] A_rgb;
  logic [11:0]     inv_t;
  logic            t_valid;
  logic [3*CW-1:0] pix_out;
  logic            out_valid;

  modport master (
    output pix_in, pix_valid, A_rgb, inv_t, t_valid,
    input  pix_out, out_valid
  );

  modport slave (
    input  pix_in, pix_valid, A_rgb, inv_t, t_valid,
    output pix_out, out_valid
  );
endinterface

// File: rtl/recover_pix.sv
// Haze removal back end: J = A + (I - A) * inv_t per colour channel.
// Pixels wait in a small FIFO until their 1/t (Q4.8) arrives; each pairing
// then runs through a latch / subtract / multiply / round-clamp pipeline.
module recover_pix #(
  parameter int DEPTH = 8,
  parameter int CW    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  recover_pix_if.slave             bus,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     err_ovf,
  output logic                     err_unf
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = CW + 14;   // product width, Q.8
  localparam int RW = PW - 8;    // rounded integer width
  localparam int JW = CW + 7;    // A + r before clamping

  // Add 0.5 LSB of the Q.8 product and drop the fraction (round half up).
  function automatic logic signed [RW-1:0] round_q8(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p + PW'(128);
    return s[PW-1:8];
  endfunction

  // Add the rounded correction to A and saturate to the channel range.
  function automatic logic [CW-1:0] clamp_px(input logic [CW-1:0] a,
                                             input logic signed [RW-1:0] r);
    logic signed [JW-1:0] j;
    j = $signed({7'b0, a}) + JW'(r);
    if (j[JW-1])            return '0;
    else if (|j[JW-2:CW])   return '1;
    else                    return j[CW-1:0];
  endfunction

  logic [3*CW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            full, empty, bypass, do_push, do_pop, accept;
  logic [3*CW-1:0] pop_pix;

  logic                   vld_p0, vld_p1, vld_p2;
  logic [3*CW-1:0]        i_p0, a_p0, a_p1, a_p2;
  logic [11:0]            inv_p0, inv_p1;
  logic signed [CW:0]     d_p1    [3];
  logic signed [PW-1:0]   prod_p2 [3];
  logic signed [PW-1:0]   prod_next [3];
  logic [3*CW-1:0]        pix_next;

  // FIFO status and the push/pop/bypass decision for this cycle.
  always_comb begin
    full    = (fifo_cnt == (AW+1)'(DEPTH));
    empty   = (fifo_cnt == '0);
    bypass  = bus.pix_valid & bus.t_valid & empty;
    do_push = bus.pix_valid & ~bypass & (~full | bus.t_valid);
    do_pop  = bus.t_valid & ~empty;
    accept  = do_pop | bypass;
    pop_pix = bypass ? bus.pix_in : mem[rd_ptr];
  end

  // FIFO pointers, occupancy and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err_ovf  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (bus.pix_valid & full & ~bus.t_valid) err_ovf <= 1'b1;
      if (bus.t_valid & empty & ~bus.pix_valid) err_unf <= 1'b1;
    end
  end

  // Pixel storage; contents are meaningless until a push, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= bus.pix_in;
  end

  // Valid shift register alongside the data stages; reset drops in-flight pixels.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= accept;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Stage p0 latches the pixel with its 1/t and A; p1 forms I - A; p2 holds the product.
  always_ff @(posedge clk) begin
    if (accept) begin
      i_p0   <= pop_pix;
      a_p0   <= bus.A_rgb;
      inv_p0 <= bus.inv_t;
    end
    for (int c = 0; c < 3; c++) begin
      d_p1[c]    <= $signed({1'b0, i_p0[c*CW +: CW]}) - $signed({1'b0, a_p0[c*CW +: CW]});
      prod_p2[c] <= prod_next[c];
    end
    a_p1   <= a_p0;
    inv_p1 <= inv_p0;
    a_p2   <= a_p1;
  end

  // Signed multiply of the difference by 1/t, and round/clamp of the held product.
  always_comb begin
    pix_next = '0;
    for (int c = 0; c < 3; c++) begin
      prod_next[c] = PW'(d_p1[c]) * PW'($signed({1'b0, inv_p1}));
      pix_next[c*CW +: CW] = clamp_px(a_p2[c*CW +: CW], round_q8(prod_p2[c]));
    end
  end

  // Output register: strobe per pixel, value held between strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.pix_out   <= '0;
    end else begin
      bus.out_valid <= vld_p2;
      if (vld_p2) bus.pix_out <= pix_next;
    end
  end
endmodule

// File: tb/tb_recover_pix.sv
// Bench for recover_pix: randomized and directed stimulus checked every cycle
// against a queue-based model of the pixel FIFO and the dehaze formula.
module tb_recover_pix;
  localparam int DEPTH = 8;
  localparam int CW    = 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] fifo_cnt;
  logic       err_ovf, err_unf;

  recover_pix_if #(.CW(CW)) bus ();

  recover_pix #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .fifo_cnt (fifo_cnt),
    .err_ovf  (err_ovf),
    .err_unf  (err_unf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: J = clamp(A + round((I - A) * inv_t / 256)), round half up.
  function automatic int recover_ch(int a, int i, int inv);
    int p, r, j;
    p = (i - a) * inv;
    r = (p + 128) >>> 8;
    j = a + r;
    if (j < 0) j = 0;
    if (j > 255) j = 255;
    return j;
  endfunction

  function automatic logic [23:0] recover_px(logic [23:0] a, logic [23:0] i, logic [11:0] inv);
    logic [23:0] r;
    r = '0;
    for (int c = 0; c < 3; c++)
      r[c*8 +: 8] = 8'(recover_ch(int'(a[c*8 +: 8]), int'(i[c*8 +: 8]), int'(inv)));
    return r;
  endfunction

  typedef struct { int due; logic [23:0] val; } exp_t;
  logic [23:0] mq[$];
  exp_t        eq[$];
  int          cyc = 0;
  logic        m_ovf = 1'b0, m_unf = 1'b0, e_v = 1'b0;
  logic [23:0] e_pix = '0;

  task automatic model_step();
    logic        push, acc;
    logic [23:0] px;
    exp_t        e;
    cyc++;
    if (!rst_n) begin
      mq.delete(); eq.delete();
      m_ovf = 1'b0; m_unf = 1'b0; e_v = 1'b0; e_pix = '0;
      return;
    end
    push = bus.pix_valid;
    acc  = 1'b0;
    px   = '0;
    if (bus.t_valid) begin
      if (mq.size() > 0) begin
        px = mq.pop_front(); acc = 1'b1;
      end else if (push) begin
        px = bus.pix_in; acc = 1'b1; push = 1'b0;
      end else m_unf = 1'b1;
    end
    if (push) begin
      if (mq.size() < DEPTH) mq.push_back(bus.pix_in);
      else m_ovf = 1'b1;
    end
    if (acc) begin
      e.due = cyc + 3;
      e.val = recover_px(bus.A_rgb, px, bus.inv_t);
      eq.push_back(e);
    end
    e_v = 1'b0;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      e = eq.pop_front();
      e_v = 1'b1; e_pix = e.val;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cyc > 0) begin
      chk("out_valid", 32'(bus.out_valid), 32'(e_v));
      chk("pix_out", 32'(bus.pix_out), 32'(e_pix));
      chk("fifo_cnt", 32'(fifo_cnt), mq.size());
      chk("err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("err_unf", 32'(err_unf), 32'(m_unf));
    end
  end

  task automatic cyc_drive(input logic pv, input logic [23:0] px, input logic tv, input logic [11:0] iv);
    bus.pix_valid = pv; bus.pix_in = px; bus.t_valid = tv; bus.inv_t = iv;
    @(posedge clk); #1;
    bus.pix_valid = 1'b0; bus.t_valid = 1'b0;
  endtask

  task automatic run_one(input logic [7:0] a, input logic [7:0] i, input logic [11:0] iv,
                         input logic [7:0] jexp, input string nm);
    bus.A_rgb = {3{a}};
    cyc_drive(1'b1, {3{i}}, 1'b1, iv);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk({nm, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_pix"}, 32'(bus.pix_out), 32'({3{jexp}}));
    chk({nm, "_cnt"}, 32'(fifo_cnt), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.pix_in = '0; bus.pix_valid = 1'b0; bus.A_rgb = '0;
    bus.inv_t = '0; bus.t_valid = 1'b0;

    chk("model_lowclamp", 32'(recover_ch(200, 100, 'h200)), 32'd0);
    chk("model_hiclamp", 32'(recover_ch(200, 250, 'h180)), 32'd255);
    chk("model_exact", 32'(recover_ch(100, 150, 'h100)), 32'd150);
    chk("model_round_up", 32'(recover_ch(100, 101, 'h180)), 32'd102);
    chk("model_round_neg", 32'(recover_ch(100, 99, 'h180)), 32'd99);

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_pix", 32'(bus.pix_out), 32'd0);
    chk("reset_cnt", 32'(fifo_cnt), 32'd0);

    // directed formula points, each a same-cycle bypass on an empty FIFO
    run_one(8'd200, 8'd100, 12'h200, 8'd0,   "low_clamp");
    run_one(8'd200, 8'd250, 12'h180, 8'd255, "high_clamp");
    run_one(8'd100, 8'd150, 12'h100, 8'd150, "exact");
    run_one(8'd100, 8'd101, 12'h180, 8'd102, "round_up");
    run_one(8'd100, 8'd99,  12'h180, 8'd99,  "round_neg");

    // underflow: t_valid on an empty FIFO
    cyc_drive(1'b0, '0, 1'b1, 12'h100);
    @(negedge clk);
    chk("unf_flag", 32'(err_unf), 32'd1);
    repeat (4) @(posedge clk);
    #1;

    // skew: fill, overflow one, then drain in order
    bus.A_rgb = 24'($urandom());
    for (int k = 0; k < DEPTH; k++) cyc_drive(1'b1, 24'($urandom()), 1'b0, '0);
    cyc_drive(1'b1, 24'hABCDEF, 1'b0, '0);
    @(negedge clk);
    chk("ovf_flag", 32'(err_ovf), 32'd1);
    chk("full_cnt", 32'(fifo_cnt), 32'd8);
    @(posedge clk); #1;
    for (int k = 0; k < DEPTH; k++) cyc_drive(1'b0, '0, 1'b1, 12'($urandom_range(0, 4095)));
    repeat (5) @(posedge clk);
    #1;

    // streaming at skew 5 with a reset in the middle
    for (int k = 0; k < 105; k++) begin
      if (k == 50) begin
        rst_n = 1'b0;
        cyc_drive(1'b1, 24'($urandom()), 1'b1, 12'($urandom_range(0, 4095)));
        @(negedge clk);
        chk("midrst_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_pix", 32'(bus.pix_out), 32'd0);
        chk("midrst_cnt", 32'(fifo_cnt), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end else begin
        if (k % 16 == 0) bus.A_rgb = 24'($urandom());
        cyc_drive(k < 100, 24'($urandom()), k >= 5, 12'($urandom_range(0, 4095)));
      end
    end

    // free-running random push/pop mix
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) bus.A_rgb = 24'($urandom());
      cyc_drive($urandom_range(0, 99) < 55, 24'($urandom()),
                $urandom_range(0, 99) < 50, 12'($urandom_range(0, 4095)));
    end
    repeat (6) @(posedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
